// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM encoding, the IF/ID payload layout and the redirect-target mux.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] next_pc;
    } fetch_pkt_t;

    localparam fetch_pkt_t BUBBLE_PKT = '{instr: NOP_INSTR, next_pc: '0};

    // JR wins over J, J wins over a taken branch.
    function automatic logic [XLEN-1:0] redirect_target(
        input logic            jr,
        input logic            j,
        input logic [XLEN-1:0] jr_addr,
        input logic [XLEN-1:0] jump_addr,
        input logic [XLEN-1:0] branch_addr
    );
        if (jr) begin
            return jr_addr;
        end else if (j) begin
            return jump_addr;
        end
        return branch_addr;
    endfunction

endpackage

// File: rtl/adder_32bits.sv
// 32-bit ripple-style adder used to form the sequential fetch address.
// Carry-out is dropped so PC arithmetic wraps modulo 2^32.
module adder_32bits
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            ci,
    output logic [XLEN-1:0] s
);

    assign s = a + b + XLEN'(ci);

endmodule

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register: req/ack instruction fetch, one-entry skid buffer
// for fetches that land during a decode stall, and wrong-path discard after redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PC_IFWrite,
    input  logic            J,
    input  logic            JR,
    input  logic            Z,
    input  logic [XLEN-1:0] BranchAddr,
    input  logic [XLEN-1:0] JumpAddr,
    input  logic [XLEN-1:0] JrAddr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instruction_id,
    output logic [XLEN-1:0] NextPC_id,
    output logic            Valid_id
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] old_addr_q, old_addr_d;
    logic            skid_valid_q, skid_valid_d;
    fetch_pkt_t      skid_q, skid_d;
    fetch_pkt_t      ifid_q, ifid_d;
    logic            valid_id_q, valid_id_d;

    logic [XLEN-1:0] pc_plus4;
    logic            redir;
    logic            fetch_ok;

    adder_32bits u_pc_adder (
        .a  (pc_q),
        .b  (INSTR_BYTES),
        .ci (1'b0),
        .s  (pc_plus4)
    );

    // The request must be combinational so zero-wait memory can ack in the same cycle.
    assign imem_req  = ~reset & ((state_q == ST_DISCARD) | ~skid_valid_q);
    assign imem_addr = (state_q == ST_DISCARD) ? old_addr_q : pc_q;

    assign redir    = PC_IFWrite & (J | JR | Z);
    assign fetch_ok = imem_ack & imem_req & (state_q == ST_RUN);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        old_addr_d   = old_addr_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        ifid_d       = ifid_q;
        valid_id_d   = valid_id_q;

        if (redir) begin
            // Squash the fall-through slot; any ack this cycle is wrong-path.
            ifid_d       = BUBBLE_PKT;
            valid_id_d   = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = redirect_target(JR, J, JrAddr, JumpAddr, BranchAddr);
            if (state_q == ST_RUN) begin
                if (imem_req && !imem_ack) begin
                    old_addr_d = pc_q;
                    state_d    = ST_DISCARD;
                end
            end else if (imem_ack) begin
                state_d = ST_RUN;
            end
        end else begin
            if (state_q == ST_DISCARD && imem_ack) begin
                state_d = ST_RUN;
            end
            if (PC_IFWrite) begin
                if (skid_valid_q) begin
                    ifid_d       = skid_q;
                    valid_id_d   = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (fetch_ok) begin
                    ifid_d     = '{instr: imem_rdata, next_pc: pc_plus4};
                    valid_id_d = 1'b1;
                end else begin
                    ifid_d     = BUBBLE_PKT;
                    valid_id_d = 1'b0;
                end
            end else if (fetch_ok && !skid_valid_q) begin
                skid_d       = '{instr: imem_rdata, next_pc: pc_plus4};
                skid_valid_d = 1'b1;
            end
            if (fetch_ok) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            old_addr_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= BUBBLE_PKT;
            ifid_q       <= BUBBLE_PKT;
            valid_id_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            old_addr_q   <= old_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            ifid_q       <= ifid_d;
            valid_id_q   <= valid_id_d;
        end
    end

    assign Instruction_id = ifid_q.instr;
    assign NextPC_id      = ifid_q.next_pc;
    assign Valid_id       = valid_id_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory
// that returns the fetch address as the instruction word.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        PC_IFWrite;
    logic        J, JR, Z;
    logic [31:0] BranchAddr, JumpAddr, JrAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_id;
    logic [31:0] NextPC_id;
    logic        Valid_id;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int cnt   = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .PC_IFWrite     (PC_IFWrite),
        .J              (J),
        .JR             (JR),
        .Z              (Z),
        .BranchAddr     (BranchAddr),
        .JumpAddr       (JumpAddr),
        .JrAddr         (JrAddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .Instruction_id (Instruction_id),
        .NextPC_id      (NextPC_id),
        .Valid_id       (Valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack once the request has waited 'lat' cycles; data = address.
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr;
    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; PC_IFWrite = 1'b1; J = 1'b0; JR = 1'b0; Z = 1'b0;
        BranchAddr = '0; JumpAddr = '0; JrAddr = '0; lat = 0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        tick(); tick();
        total++; if (Valid_id !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", Valid_id); end
        total++; if (Instruction_id !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", Instruction_id); end
        total++; if (NextPC_id !== 32'h0) begin bad++; $display("FAIL rst_npc got=%h exp=0", NextPC_id); end
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_a;
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'(i * 4);
            tick();
            total++; if (Valid_id !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, Valid_id); end
            total++; if (Instruction_id !== exp_a) begin bad++; $display("FAIL zw_instr[%0d] got=%h exp=%h", i, Instruction_id, exp_a); end
            total++; if (NextPC_id !== exp_a + 32'd4) begin bad++; $display("FAIL zw_npc[%0d] got=%h exp=%h", i, NextPC_id, exp_a + 32'd4); end
        end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL zw_addr got=%h exp=10", imem_addr); end
    endtask

    task automatic test_stall_skid();
        PC_IFWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (Instruction_id !== 32'hC) begin bad++; $display("FAIL stall_hold[%0d] got=%h exp=c", i, Instruction_id); end
            total++; if (Valid_id !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, Valid_id); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_req); end
        end
        PC_IFWrite = 1'b1;
        tick();
        total++; if (Instruction_id !== 32'h10) begin bad++; $display("FAIL skid_out_instr got=%h exp=10", Instruction_id); end
        total++; if (NextPC_id !== 32'h14) begin bad++; $display("FAIL skid_out_npc got=%h exp=14", NextPC_id); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL skid_req_back got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL skid_next_addr got=%h exp=14", imem_addr); end
        tick();
        total++; if (Instruction_id !== 32'h14) begin bad++; $display("FAIL post_skid_instr got=%h exp=14", Instruction_id); end
        total++; if (Valid_id !== 1'b1) begin bad++; $display("FAIL post_skid_valid got=%b exp=1", Valid_id); end
    endtask

    task automatic test_branch();
        tick(); tick();
        total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL br_pc got=%h exp=20", imem_addr); end
        Z = 1'b1; BranchAddr = 32'h100;
        tick();
        Z = 1'b0;
        #1;
        total++; if (Valid_id !== 1'b0) begin bad++; $display("FAIL br_bubble_valid got=%b exp=0", Valid_id); end
        total++; if (Instruction_id !== 32'h0) begin bad++; $display("FAIL br_bubble_instr got=%h exp=0", Instruction_id); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL br_target_addr got=%h exp=100", imem_addr); end
        tick();
        total++; if (Instruction_id !== 32'h100) begin bad++; $display("FAIL br_target_instr got=%h exp=100", Instruction_id); end
        total++; if (NextPC_id !== 32'h104) begin bad++; $display("FAIL br_target_npc got=%h exp=104", NextPC_id); end
        total++; if (Valid_id !== 1'b1) begin bad++; $display("FAIL br_target_valid got=%b exp=1", Valid_id); end
    endtask

    task automatic test_jump_discard();
        J = 1'b1; JumpAddr = 32'h40;
        tick();
        J = 1'b0; lat = 2;
        #1;
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL jd_fetch40 got=%h exp=40", imem_addr); end
        J = 1'b1; JumpAddr = 32'h400;
        tick();
        J = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL jd_hold_addr[%0d] got=%h exp=40", i, imem_addr); end
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL jd_hold_req[%0d] got=%b exp=1", i, imem_req); end
            total++; if (Valid_id !== 1'b0) begin bad++; $display("FAIL jd_hold_valid[%0d] got=%b exp=0", i, Valid_id); end
            tick();
        end
        total++; if (imem_addr !== 32'h400) begin bad++; $display("FAIL jd_next_addr got=%h exp=400", imem_addr); end
        total++; if (Valid_id !== 1'b0) begin bad++; $display("FAIL jd_dropped got=%b exp=0", Valid_id); end
        tick(); tick();
        total++; if (Valid_id !== 1'b0) begin bad++; $display("FAIL jd_wait_valid got=%b exp=0", Valid_id); end
        tick();
        total++; if (Instruction_id !== 32'h400) begin bad++; $display("FAIL jd_target_instr got=%h exp=400", Instruction_id); end
        total++; if (NextPC_id !== 32'h404) begin bad++; $display("FAIL jd_target_npc got=%h exp=404", NextPC_id); end
    endtask

    task automatic test_priority_and_stall_redirect();
        lat = 0;
        JR = 1'b1; J = 1'b1; Z = 1'b1;
        JrAddr = 32'h800; JumpAddr = 32'h900; BranchAddr = 32'hA00;
        tick();
        JR = 1'b0; J = 1'b0; Z = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h800) begin bad++; $display("FAIL prio_addr got=%h exp=800", imem_addr); end
        tick();
        total++; if (Instruction_id !== 32'h800) begin bad++; $display("FAIL prio_instr got=%h exp=800", Instruction_id); end
        PC_IFWrite = 1'b0; Z = 1'b1; BranchAddr = 32'hC00;
        tick();
        total++; if (Instruction_id !== 32'h800) begin bad++; $display("FAIL stz_hold got=%h exp=800", Instruction_id); end
        total++; if (Valid_id !== 1'b1) begin bad++; $display("FAIL stz_valid got=%b exp=1", Valid_id); end
        PC_IFWrite = 1'b1; Z = 1'b0;
        tick();
        total++; if (Instruction_id !== 32'h804) begin bad++; $display("FAIL stz_next_instr got=%h exp=804", Instruction_id); end
        total++; if (Valid_id !== 1'b1) begin bad++; $display("FAIL stz_next_valid got=%b exp=1", Valid_id); end
        total++; if (imem_addr !== 32'h808) begin bad++; $display("FAIL stz_addr got=%h exp=808", imem_addr); end
    endtask

    task automatic test_reset_in_discard();
        lat = 2;
        J = 1'b1; JumpAddr = 32'h1000;
        tick();
        J = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h808) begin bad++; $display("FAIL rd_discard_addr got=%h exp=808", imem_addr); end
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rd_req_in_reset got=%b exp=0", imem_req); end
        tick();
        reset = 1'b0; lat = 0;
        #1;
        total++; if (Valid_id !== 1'b0) begin bad++; $display("FAIL rd_valid got=%b exp=0", Valid_id); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rd_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rd_pc got=%h exp=0", imem_addr); end
        tick();
        total++; if (Valid_id !== 1'b1) begin bad++; $display("FAIL rd_resume_valid got=%b exp=1", Valid_id); end
        total++; if (NextPC_id !== 32'h4) begin bad++; $display("FAIL rd_resume_npc got=%h exp=4", NextPC_id); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_branch();
        test_jump_discard();
        test_priority_and_stall_redirect();
        test_reset_in_discard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It consumes the redirect and stall signals produced by the decode stage (J, JR, Z, BranchAddr, JumpAddr, JrAddr, PC_IFWrite) and drives Instruction_id / NextPC_id into decode. It fetches from instruction memory over a req/ack handshake with variable latency. A one-entry skid buffer absorbs a fetch that completes while decode is stalled, and in-flight wrong-path fetches are discarded after a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded by reset.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- PC_IFWrite  in  1  1 = IF/ID may advance; 0 = stall (hold IF/ID).
- J  in  1  jump redirect from decode.
- JR  in  1  register-jump redirect from decode.
- Z  in  1  branch-taken redirect from decode.
- BranchAddr / JumpAddr / JrAddr  in  32  redirect targets.
- imem_req  out  1  fetch request; held with stable imem_addr until ack.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  fetch complete; only asserted in cycles with imem_req=1; may arrive in the same cycle as the request.
- imem_rdata  in  32  instruction, valid in the ack cycle.
- Instruction_id  out  32  IF/ID instruction; 32'h0 (sll NOP) when bubble.
- NextPC_id  out  32  fetched address + 4; 0 when bubble.
- Valid_id  out  1  IF/ID holds a real instruction.

## Operation
- adv = PC_IFWrite. redir = adv & (J|JR|Z). Redirects are ignored while stalled.
- Target priority: JR→JrAddr, else J→JumpAddr, else Z→BranchAddr.
- The core has no delay slot. The instruction fetched behind a redirecting instruction is squashed.
- States:
  - RUN: imem_req = ~skid_valid & ~reset, with imem_addr = PC.
  - DISCARD: imem_req = 1, with imem_addr = the captured old address, until ack. rdata is dropped; the next state is RUN.
- redir cycle:
  - IF/ID ← bubble; skid cleared; PC ← target.
  - If imem_req & ~imem_ack, capture the old address and go to DISCARD.
  - An ack arriving in this cycle is dropped.
- adv & ~redir:
  - If skid_valid, IF/ID ← skid and skid is cleared.
  - Else if ack, IF/ID ← {rdata, addr+4, valid}.
  - Else IF/ID ← bubble.
- ~adv: IF/ID holds. On ack with skid empty, skid ← {rdata, addr+4}.
- PC ← PC+4 on every accepted ack (not in DISCARD, not on a redir cycle). Arithmetic is 32-bit and wraps modulo 2^32.
- Reset values: PC=RESET_PC, Instruction_id=0, NextPC_id=0, Valid_id=0, skid empty, state RUN, imem_req=0 during reset.
- Reset mid-DISCARD or mid-request abandons the request. Instruction memory shares the same reset.

## Timing
- Zero-wait memory (ack in request cycle): instruction at PC is in IF/ID at the next edge. Throughput is 1 instruction/cycle.
- N-cycle ack: IF/ID is valid the edge after ack, with bubbles in between.
- Taken redirect in cycle n, with no outstanding request:
  - IF/ID bubble at n+1.
  - Target fetched in n+1.
  - Target in IF/ID at n+2 (zero-wait).
- Redirect with outstanding request: the target fetch starts the cycle after the discarded ack.
- Skid drain: once the skid empties, imem_req reasserts in the following cycle. This costs a one-cycle fetch gap after a stall.

## Structure
- Shared package holds:
  - state encoding (RUN, DISCARD)
  - NOP constant 32'h0
  - default RESET_PC
- Sub-module: adder_32bits computes PC+4 (a=PC, b=32'd4, ci=0).
- The skid buffer and IF/ID register are inline registers in this module.

## Test plan
- Reset, then zero-wait memory returning addr-tagged data. Required: Instruction_id sequence from 0x0, 0x4, 0x8 … one per cycle; NextPC_id = 0x4, 0x8, 0xC.
- PC_IFWrite=0 for 3 cycles, with ack in the first stall cycle. Required:
  - IF/ID held.
  - Skid captures the instruction.
  - imem_req=0 until the stall ends.
  - On release, IF/ID ← skid contents with no instruction lost or duplicated.
- Z=1 with BranchAddr=0x100 at PC=0x20, zero-wait. Required: IF/ID bubble (Valid_id=0, Instruction_id=0) next cycle, then Instruction_id from 0x100 with NextPC_id=0x104.
- 3-cycle memory, and J=1 with JumpAddr=0x400 while fetching 0x40. Required:
  - imem_addr stays 0x40 until ack.
  - That data never reaches IF/ID.
  - Next request is 0x400.
- JR=1, J=1, Z=1 together with distinct targets. Required: PC ← JrAddr. Also: Z=1 while PC_IFWrite=0 produces no redirect.
- reset asserted during DISCARD. Required: next cycle PC=RESET_PC, Valid_id=0, imem_req=0 in the reset cycle, fetch resumes from RESET_PC.
